// File: rtl/mac_array_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mac_array_sequencer
// Purpose  : Programmable control sequencer for the MAC array. A conv command
//            fetches a KxK weight kernel from weight BRAM into the weight
//            preload chains, commits it into the MACs, then streams ifmaps
//            windows from the input FIFO with empty-aware flow control. One
//            compute strobe per window; a valid strobe follows MAC_LATENCY
//            cycles later. The pool command (MAC_POOL_EN) skips the weight
//            phase and leaves the MAC weights untouched.
// Ports    : clk, rst (async, active-high)
//            start, abort, op, kernel_size, weight_base_addr, num_windows
//                                            - command inputs
//            bram_rd_en, bram_addr, bram_rdata - weight BRAM read port
//            weight_shift_en, mac_load_weight  - weight preload control
//            ifmaps_fifo_empty, ifmaps_fifo_rd_en - ifmaps FIFO handshake
//            mac_load_ifmaps, mac_compute, mac_o_valid - MAC array control
//            busy, done, err                 - status (done/err are pulses)
// Config   : `define MAC_POOL_EN enables op=1 (pool); otherwise op=1 errors.
// Revision : 1.0 - initial release
// ============================================================================
module mac_array_sequencer #(
  parameter int MAC_NUM            = 256,
  parameter int DATA_W             = 5,
  parameter int MAX_K              = 5,
  parameter int BRAM_ADDRESS_WIDTH = 12,
  parameter int WIN_W              = 16,
  parameter int MAC_LATENCY        = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic [1:0]                    op,
  input  logic [2:0]                    kernel_size,
  input  logic [BRAM_ADDRESS_WIDTH-1:0] weight_base_addr,
  input  logic [WIN_W-1:0]              num_windows,
  output logic                          bram_rd_en,
  output logic [BRAM_ADDRESS_WIDTH-1:0] bram_addr,
  input  logic [DATA_W*MAC_NUM-1:0]     bram_rdata,
  output logic                          weight_shift_en,
  output logic                          mac_load_weight,
  input  logic                          ifmaps_fifo_empty,
  output logic                          ifmaps_fifo_rd_en,
  output logic                          mac_load_ifmaps,
  output logic                          mac_compute,
  output logic                          mac_o_valid,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  localparam int c_KK_W = $clog2(MAX_K * MAX_K + 1);
  // All valid-pipe stages except the output stage: a strobe still travelling.
  localparam logic [MAC_LATENCY-1:0] c_VPIPE_BODY =
      MAC_LATENCY'((1 << (MAC_LATENCY - 1)) - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_COMMIT = 3'd2,
    S_STREAM = 3'd3,
    S_DRAIN  = 3'd4
  } state_t;

  state_t                          r_state;
  logic [c_KK_W-1:0]               r_kk;
  logic [WIN_W-1:0]                r_num_win;
  logic [c_KK_W-1:0]               r_rd_cnt;
  logic [c_KK_W-1:0]               r_elem_cnt;
  logic [WIN_W-1:0]                r_win_cnt;
  logic                            r_bram_rd_en;
  logic [BRAM_ADDRESS_WIDTH-1:0]   r_bram_addr;
  logic                            r_shift_en;
  logic                            r_load_weight;
  logic                            r_load_ifmaps;
  logic                            r_compute;
  logic [MAC_LATENCY-1:0]          r_vpipe;
  logic                            r_done;
  logic                            r_err;

  logic w_k_ok;
  logic w_op_ok;
  logic w_cmd_ok;
  logic w_pop;
  logic w_unused;

  // Weight data goes straight from BRAM to the preload chains, not through here.
  assign w_unused = ^bram_rdata;

  assign w_k_ok = (kernel_size != 3'd0) && (int'(kernel_size) <= MAX_K);
`ifdef MAC_POOL_EN
  assign w_op_ok = (op == 2'd0) || (op == 2'd1);
`else
  assign w_op_ok = (op == 2'd0);
`endif
  assign w_cmd_ok = w_k_ok && w_op_ok && (num_windows != '0);

  // Pop is combinational on empty so a window streams with no bubbles.
  assign w_pop = (r_state == S_STREAM) && !ifmaps_fifo_empty &&
                 (r_win_cnt != r_num_win);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_kk          <= '0;
      r_num_win     <= '0;
      r_rd_cnt      <= '0;
      r_elem_cnt    <= '0;
      r_win_cnt     <= '0;
      r_bram_rd_en  <= 1'b0;
      r_bram_addr   <= '0;
      r_shift_en    <= 1'b0;
      r_load_weight <= 1'b0;
      r_load_ifmaps <= 1'b0;
      r_compute     <= 1'b0;
      r_vpipe       <= '0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_load_weight <= 1'b0;
      r_compute     <= 1'b0;
      r_shift_en    <= r_bram_rd_en;
      r_load_ifmaps <= w_pop;
      r_vpipe       <= (r_vpipe << 1) | MAC_LATENCY'(r_compute);

      if (abort) begin
        // The element popped this cycle is dropped: load_ifmaps is not raised.
        r_state       <= S_IDLE;
        r_bram_rd_en  <= 1'b0;
        r_shift_en    <= 1'b0;
        r_load_ifmaps <= 1'b0;
        r_vpipe       <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              if (!w_cmd_ok) begin
                r_err <= 1'b1;
              end else begin
                r_kk       <= c_KK_W'(kernel_size) * c_KK_W'(kernel_size);
                r_num_win  <= num_windows;
                r_rd_cnt   <= '0;
                r_elem_cnt <= '0;
                r_win_cnt  <= '0;
                if (op == 2'd0) begin
                  r_state      <= S_LOAD_W;
                  r_bram_rd_en <= 1'b1;
                  r_bram_addr  <= weight_base_addr;
                end else begin
                  r_state <= S_STREAM;
                end
              end
            end
          end

          S_LOAD_W: begin
            if (r_bram_rd_en) begin
              if (r_rd_cnt == r_kk - c_KK_W'(1)) begin
                r_bram_rd_en <= 1'b0;
              end else begin
                r_bram_addr <= r_bram_addr + BRAM_ADDRESS_WIDTH'(1);
                r_rd_cnt    <= r_rd_cnt + c_KK_W'(1);
              end
            end else if (r_shift_en) begin
              // Final shift is happening now; commit next cycle.
              r_state       <= S_COMMIT;
              r_load_weight <= 1'b1;
            end
          end

          S_COMMIT: r_state <= S_STREAM;

          S_STREAM: begin
            if (w_pop) begin
              // Counters run on the pop side; the compute strobe lands one
              // cycle later, aligned with delivery of the window's last element.
              if (r_elem_cnt == r_kk - c_KK_W'(1)) begin
                r_elem_cnt <= '0;
                r_compute  <= 1'b1;
                r_win_cnt  <= r_win_cnt + WIN_W'(1);
                if (r_win_cnt + WIN_W'(1) == r_num_win) begin
                  r_state <= S_DRAIN;
                end
              end else begin
                r_elem_cnt <= r_elem_cnt + c_KK_W'(1);
              end
            end
          end

          S_DRAIN: begin
            // Done lands the cycle after the last valid leaves the pipe.
            if (!r_compute && ((r_vpipe & c_VPIPE_BODY) == '0)) begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end
          end

          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bram_rd_en        = r_bram_rd_en;
  assign bram_addr         = r_bram_addr;
  assign weight_shift_en   = r_shift_en;
  assign mac_load_weight   = r_load_weight;
  assign ifmaps_fifo_rd_en = w_pop;
  assign mac_load_ifmaps   = r_load_ifmaps;
  assign mac_compute       = r_compute;
  assign mac_o_valid       = r_vpipe[MAC_LATENCY-1];
  assign busy              = (r_state != S_IDLE);
  assign done              = r_done;
  assign err               = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mac_array_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_array_sequencer
// Purpose  : Directed bench for mac_array_sequencer. Each command is started
//            in "cycle 0"; a negedge monitor records every output strobe per
//            cycle so the checks compare against hand-computed cycle numbers.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_array_sequencer;

  localparam int MAC_NUM = 256;
  localparam int DATA_W  = 5;
  localparam int MAX_K   = 5;
  localparam int BAW     = 12;
  localparam int WIN_W   = 16;
  localparam int LAT     = 2;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      start = 1'b0;
  logic                      abort = 1'b0;
  logic [1:0]                op = 2'd0;
  logic [2:0]                kernel_size = 3'd0;
  logic [BAW-1:0]            weight_base_addr = '0;
  logic [WIN_W-1:0]          num_windows = '0;
  logic                      bram_rd_en;
  logic [BAW-1:0]            bram_addr;
  logic [DATA_W*MAC_NUM-1:0] bram_rdata = '0;
  logic                      weight_shift_en;
  logic                      mac_load_weight;
  logic                      ifmaps_fifo_empty = 1'b0;
  logic                      ifmaps_fifo_rd_en;
  logic                      mac_load_ifmaps;
  logic                      mac_compute;
  logic                      mac_o_valid;
  logic                      busy;
  logic                      done;
  logic                      err;

  mac_array_sequencer #(
    .MAC_NUM(MAC_NUM), .DATA_W(DATA_W), .MAX_K(MAX_K),
    .BRAM_ADDRESS_WIDTH(BAW), .WIN_W(WIN_W), .MAC_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .op(op),
    .kernel_size(kernel_size), .weight_base_addr(weight_base_addr),
    .num_windows(num_windows), .bram_rd_en(bram_rd_en), .bram_addr(bram_addr),
    .bram_rdata(bram_rdata), .weight_shift_en(weight_shift_en),
    .mac_load_weight(mac_load_weight), .ifmaps_fifo_empty(ifmaps_fifo_empty),
    .ifmaps_fifo_rd_en(ifmaps_fifo_rd_en), .mac_load_ifmaps(mac_load_ifmaps),
    .mac_compute(mac_compute), .mac_o_valid(mac_o_valid), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // ---------------- monitor: per-cycle history of each strobe ----------------
  int ncnt = 0;
  int t0   = 1 << 30;
  int cyc;
  int bad_pop = 0;
  logic alt = 1'b0;
  logic [127:0] h_rd, h_sh, h_lw, h_pop, h_li, h_cmp, h_val, h_done, h_err, h_busy;
  logic [BAW-1:0] addrq[$];

  always @(negedge clk) begin
    ncnt++;
    cyc = ncnt - t0;
    if (cyc >= 0 && cyc < 128) begin
      h_rd[cyc]   = bram_rd_en;
      h_sh[cyc]   = weight_shift_en;
      h_lw[cyc]   = mac_load_weight;
      h_pop[cyc]  = ifmaps_fifo_rd_en;
      h_li[cyc]   = mac_load_ifmaps;
      h_cmp[cyc]  = mac_compute;
      h_val[cyc]  = mac_o_valid;
      h_done[cyc] = done;
      h_err[cyc]  = err;
      h_busy[cyc] = busy;
      if (bram_rd_en) addrq.push_back(bram_addr);
    end
    if (ifmaps_fifo_rd_en && ifmaps_fifo_empty) bad_pop++;
  end

  // FIFO model: always full, or empty on every other cycle.
  always @(negedge clk) begin
    #2;
    ifmaps_fifo_empty = alt ? ((ncnt % 2) == 1) : 1'b0;
  end

  function automatic int first1(input logic [127:0] v);
    for (int i = 0; i < 128; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int last1(input logic [127:0] v);
    for (int i = 127; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  // Issue one command in cycle 0 and observe 90 cycles; abort_at < 0 = none.
  task automatic run(input logic [1:0] o, input logic [2:0] k, input logic [BAW-1:0] base,
                     input logic [WIN_W-1:0] nw, input logic a, input int abort_at);
    @(negedge clk); #1;
    t0 = ncnt;
    {h_rd, h_sh, h_lw, h_pop, h_li} = '0;
    {h_cmp, h_val, h_done, h_err, h_busy} = '0;
    addrq.delete();
    bad_pop = 0;
    alt = a;
    op = o; kernel_size = k; weight_base_addr = base; num_windows = nw;
    start = 1'b1;
    for (int c = 1; c < 90; c++) begin
      @(negedge clk); #1;
      start = 1'b0;
      abort = (c == abort_at);
    end
    abort = 1'b0;
  endtask

  initial begin
    // ---------------- reset ----------------
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    check("reset_strobes", {22'd0, bram_rd_en, weight_shift_en, mac_load_weight,
          ifmaps_fifo_rd_en, mac_load_ifmaps, mac_compute, mac_o_valid, busy, done, err}, 32'd0);
    check("reset_addr", 32'(bram_addr), 32'd0);

    // ---------------- conv K=3, wrap-around base, FIFO full ----------------
    run(2'd0, 3'd3, 12'hFFE, 16'd2, 1'b0, -1);
    check("conv_rd_count", $countones(h_rd), 9);
    check("conv_rd_first", first1(h_rd), 1);
    check("conv_rd_last", last1(h_rd), 9);
    check("conv_addr_n", addrq.size(), 9);
    check("conv_addr0", 32'(addrq[0]), 32'h0FFE);
    check("conv_addr1", 32'(addrq[1]), 32'h0FFF);
    check("conv_addr2", 32'(addrq[2]), 32'h0000);
    check("conv_addr8", 32'(addrq[8]), 32'h0006);
    check("conv_shift_count", $countones(h_sh), 9);
    check("conv_shift_first", first1(h_sh), 2);
    check("conv_shift_last", last1(h_sh), 10);
    check("conv_lw_count", $countones(h_lw), 1);
    check("conv_lw_cycle", first1(h_lw), 11);
    check("conv_pop_count", $countones(h_pop), 18);
    check("conv_pop_first", first1(h_pop), 12);
    check("conv_li_count", $countones(h_li), 18);
    check("conv_li_first", first1(h_li), 13);
    check("conv_cmp_count", $countones(h_cmp), 2);
    check("conv_cmp_first", first1(h_cmp), 21);
    check("conv_cmp_last", last1(h_cmp), 30);
    check("conv_val_first", first1(h_val), 21 + LAT);
    check("conv_val_last", last1(h_val), 30 + LAT);
    check("conv_done_count", $countones(h_done), 1);
    check("conv_done_cycle", first1(h_done), 31 + LAT);
    check("conv_busy_count", $countones(h_busy), 30 + LAT);
    check("conv_err", $countones(h_err), 0);

    // ---------------- FIFO empty every other cycle ----------------
    run(2'd0, 3'd3, 12'h010, 16'd2, 1'b1, -1);
    check("alt_pop_when_empty", bad_pop, 0);
    check("alt_li_count", $countones(h_li), 18);
    check("alt_cmp_count", $countones(h_cmp), 2);
    check("alt_val_count", $countones(h_val), 2);
    check("alt_done_count", $countones(h_done), 1);
    alt = 1'b0;

    // ---------------- illegal commands ----------------
    run(2'd0, 3'd0, 12'h000, 16'd1, 1'b0, -1);
    check("k0_err", $countones(h_err), 1);
    check("k0_quiet", $countones(h_busy | h_rd | h_pop), 0);
    run(2'd0, 3'd6, 12'h000, 16'd1, 1'b0, -1);
    check("k6_err", $countones(h_err), 1);
    check("k6_quiet", $countones(h_busy | h_rd | h_pop), 0);
    run(2'd0, 3'd3, 12'h000, 16'd0, 1'b0, -1);
    check("nw0_err", $countones(h_err), 1);
    check("nw0_quiet", $countones(h_busy | h_rd | h_pop), 0);
    run(2'd2, 3'd3, 12'h000, 16'd1, 1'b0, -1);
    check("op2_err", $countones(h_err), 1);
    check("op2_quiet", $countones(h_busy | h_rd | h_pop), 0);

    // ---------------- abort after 4 delivered elements ----------------
    run(2'd0, 3'd3, 12'h000, 16'd2, 1'b0, 16);
    check("abort_li_count", $countones(h_li), 4);
    check("abort_pop_count", $countones(h_pop), 5);
    check("abort_busy_after", h_busy[17], 0);
    check("abort_busy_last", last1(h_busy), 16);
    check("abort_no_cmp", $countones(h_cmp), 0);
    check("abort_no_val", $countones(h_val), 0);
    check("abort_no_done", $countones(h_done), 0);
    run(2'd0, 3'd3, 12'h000, 16'd2, 1'b0, -1);
    check("post_abort_cmp", $countones(h_cmp), 2);
    check("post_abort_done", first1(h_done), 31 + LAT);

    // ---------------- pool K=2, 3 windows ----------------
    run(2'd1, 3'd2, 12'h000, 16'd3, 1'b0, -1);
`ifdef MAC_POOL_EN
    check("pool_no_bram", $countones(h_rd | h_sh | h_lw), 0);
    check("pool_pops", $countones(h_pop), 12);
    check("pool_cmp", $countones(h_cmp), 3);
    check("pool_done", $countones(h_done), 1);
`else
    check("pool_err", $countones(h_err), 1);
    check("pool_quiet", $countones(h_busy | h_rd | h_pop), 0);
`endif

    // ---------------- asynchronous reset mid-LOAD_W ----------------
    @(negedge clk); #1;
    op = 2'd0; kernel_size = 3'd3; weight_base_addr = 12'h020; num_windows = 16'd1;
    start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_async_rd", {31'd0, bram_rd_en}, 0);
    check("rst_async_busy", {31'd0, busy}, 0);
    check("rst_async_addr", 32'(bram_addr), 0);
    @(negedge clk); #1 rst = 1'b0;
    @(negedge clk); #1;
    check("rst_idle_busy", {31'd0, busy}, 0);
    run(2'd0, 3'd1, 12'h005, 16'd1, 1'b0, -1);
    check("k1_addr", 32'(addrq[0]), 5);
    check("k1_cmp_cycle", first1(h_cmp), 5);
    check("k1_done_cycle", first1(h_done), 6 + LAT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
